// File: rtl/cfglut_pkg.sv
// Shared constants and state encoding for the CFGLUT5 chain loader.
package cfglut_pkg;

    localparam int unsigned LUT_BITS    = 32;
    localparam int unsigned NUM_LUT_MAX = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/cfglut_shreg.sv
// W-bit shift register with parallel load, serial input and a terminal-count flag.
module cfglut_shreg #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift,
    input  logic         sin,
    output logic [W-1:0] q,
    output logic         last_c
);

    localparam int unsigned CNT_W = $clog2(W);

    logic [CNT_W-1:0] cnt;

    // Load wins over shift; the FSM never asserts both together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            cnt <= '0;
        end else if (load) begin
            q   <= load_data;
            cnt <= '0;
        end else if (shift) begin
            q   <= {q[W-2:0], sin};
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign last_c = (cnt == CNT_W'(W - 1));

endmodule

// File: rtl/cfglut_loader.sv
// Serial writer for a chain of CFGLUT5-style LUTs; captures displaced contents as readback.
module cfglut_loader
    import cfglut_pkg::*;
#(
    parameter int unsigned NUM_LUT = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic                        ld_restore,
    input  logic [NUM_LUT*LUT_BITS-1:0] ld_data,
    output logic                        busy,
    output logic                        cfg_ce,
    output logic                        cfg_cdi,
    input  logic                        cfg_cdo,
    output logic                        rb_valid,
    output logic [NUM_LUT*LUT_BITS-1:0] rb_data
);

    localparam int unsigned W = NUM_LUT * LUT_BITS;

    state_t         state;
    state_t         state_next;
    logic           restore;
    logic           accept;
    logic           shift;
    logic           last_c;
    logic [W-1:0]   shreg_q;
    logic [W-1:0]   load_data;

    // Restore starts from zero so the register fills purely with CDO bits.
    assign load_data = ld_restore ? '0 : ld_data;

    cfglut_shreg #(
        .W (W)
    ) u_shreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_data (load_data),
        .shift     (shift),
        .sin       (cfg_cdo),
        .q         (shreg_q),
        .last_c    (last_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                if (ld_valid) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (last_c) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Final shift edge completes the old image; capture it including the last CDO bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            restore <= 1'b0;
            rb_data <= '0;
        end else begin
            if (accept) begin
                restore <= ld_restore;
            end
            if (shift && last_c) begin
                rb_data <= {shreg_q[W-2:0], cfg_cdo};
            end
        end
    end

    assign ld_ready = (state == IDLE);
    assign busy     = (state == SHIFT);
    assign cfg_ce   = (state == SHIFT);
    assign rb_valid = (state == DONE);
    assign cfg_cdi  = (state == SHIFT) && (restore ? cfg_cdo : shreg_q[W-1]);

endmodule

// File: tb/tb_cfglut_loader.sv
// Directed bench: two loaders (1 and 2 LUTs) each closing the loop through a behavioral CFGLUT5 chain.
module tb_cfglut_loader;
    import cfglut_pkg::*;

    localparam int unsigned WA = LUT_BITS;
    localparam int unsigned WB = 2 * LUT_BITS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic          ld_valid_a, ld_ready_a, ld_restore_a, busy_a, ce_a, cdi_a, cdo_a, rb_valid_a;
    logic [WA-1:0] ld_data_a, rb_data_a;
    logic          ld_valid_b, ld_ready_b, ld_restore_b, busy_b, ce_b, cdi_b, cdo_b, rb_valid_b;
    logic [WB-1:0] ld_data_b, rb_data_b;

    int checks = 0;
    int errors = 0;

    cfglut_loader #(.NUM_LUT(1)) dut_a (
        .clk (clk), .rst_n (rst_n),
        .ld_valid (ld_valid_a), .ld_ready (ld_ready_a), .ld_restore (ld_restore_a), .ld_data (ld_data_a),
        .busy (busy_a), .cfg_ce (ce_a), .cfg_cdi (cdi_a), .cfg_cdo (cdo_a),
        .rb_valid (rb_valid_a), .rb_data (rb_data_a)
    );

    cfglut_loader #(.NUM_LUT(2)) dut_b (
        .clk (clk), .rst_n (rst_n),
        .ld_valid (ld_valid_b), .ld_ready (ld_ready_b), .ld_restore (ld_restore_b), .ld_data (ld_data_b),
        .busy (busy_b), .cfg_ce (ce_b), .cfg_cdi (cdi_b), .cfg_cdo (cdo_b),
        .rb_valid (rb_valid_b), .rb_data (rb_data_b)
    );

    // Behavioral CFGLUT5 chains: shift CDI into bit 0, CDO is INIT[31].
    logic [31:0] init_a  = '0;
    logic [31:0] init_b0 = '0;
    logic [31:0] init_b1 = '0;

    always @(posedge clk) if (ce_a) init_a <= {init_a[30:0], cdi_a};
    assign cdo_a = init_a[31];

    always @(posedge clk) begin
        if (ce_b) begin
            init_b0 <= {init_b0[30:0], cdi_b};
            init_b1 <= {init_b1[30:0], init_b0[31]};
        end
    end
    assign cdo_b = init_b1[31];

    function automatic logic lut_out(input logic [31:0] init, input logic [4:0] sel);
        return init[sel];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One complete transfer on the single-LUT loader with timing and content checks.
    task automatic run_a(input string tag, input logic restore, input logic [31:0] data,
                         input logic [31:0] exp_rb);
        int          ce_n, ce_first, rb_n, rb_cyc, rdy_cyc, busy_bad, wait_n;
        logic [31:0] cdi_seq, rb, exp_img;
        ce_n = 0; ce_first = 0; rb_n = 0; rb_cyc = 0; rdy_cyc = 0; busy_bad = 0; wait_n = 0;
        cdi_seq = '0; rb = '0;
        exp_img = restore ? exp_rb : data;
        while (!ld_ready_a && wait_n < 100) begin
            tick;
            wait_n++;
        end
        chk({tag, " idle"}, 64'(ld_ready_a), 64'(1));
        ld_restore_a = restore;
        ld_data_a    = data;
        ld_valid_a   = 1'b1;
        tick;
        ld_valid_a   = 1'b0;
        ld_restore_a = ~restore;
        ld_data_a    = $urandom;
        for (int c = 1; c <= int'(WA) + 4; c++) begin
            if (ce_a) begin
                ce_n++;
                cdi_seq = {cdi_seq[30:0], cdi_a};
                if (ce_first == 0) ce_first = c;
            end
            if (busy_a !== ce_a) busy_bad++;
            if (rb_valid_a) begin
                rb_n++;
                rb_cyc = c;
                rb     = rb_data_a;
            end
            if (ld_ready_a && rdy_cyc == 0) rdy_cyc = c;
            tick;
        end
        chk({tag, " ce_cycles"}, 64'(ce_n), 64'(32));
        chk({tag, " ce_first"}, 64'(ce_first), 64'(1));
        chk({tag, " cdi_seq"}, 64'(cdi_seq), 64'(exp_img));
        chk({tag, " busy"}, 64'(busy_bad), 64'(0));
        chk({tag, " rb_pulses"}, 64'(rb_n), 64'(1));
        chk({tag, " rb_cycle"}, 64'(rb_cyc), 64'(33));
        chk({tag, " ready_cycle"}, 64'(rdy_cyc), 64'(34));
        chk({tag, " rb_data"}, 64'(rb), 64'(exp_rb));
        chk({tag, " rb_hold"}, 64'(rb_data_a), 64'(exp_rb));
        chk({tag, " lut_init"}, 64'(init_a), 64'(exp_img));
    endtask

    int          bce, bfirst, brb_n, brb_cyc, brdy, bbusy_bad;
    logic [63:0] brb;
    logic [31:0] acc_data [4];
    logic [31:0] rb_log   [4];
    int          acc_n, rb_n2, last_acc, gap_bad, rb_seen;
    logic [31:0] x_prev, d_abort, partial;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ld_valid_a = 1'b0; ld_restore_a = 1'b0; ld_data_a = '0;
        ld_valid_b = 1'b0; ld_restore_b = 1'b0; ld_data_b = '0;
        tick;
        tick;
        chk("rst ready_a", 64'(ld_ready_a), 64'(1));
        chk("rst busy_a", 64'(busy_a), 64'(0));
        chk("rst ce_a", 64'(ce_a), 64'(0));
        chk("rst cdi_a", 64'(cdi_a), 64'(0));
        chk("rst rb_valid_a", 64'(rb_valid_a), 64'(0));
        chk("rst rb_data_a", 64'(rb_data_a), 64'(0));
        chk("rst ready_b", 64'(ld_ready_b), 64'(1));
        chk("rst ce_b", 64'(ce_b), 64'(0));
        chk("rst rb_data_b", rb_data_b, 64'(0));
        rst_n = 1'b1;
        tick;

        run_a("load1", 1'b0, 32'hCAFE_F00D, 32'h0000_0000);
        chk("load1 lut_i00", 64'(lut_out(init_a, 5'h00)), 64'(1));
        chk("load1 lut_i1f", 64'(lut_out(init_a, 5'h1F)), 64'(1));
        chk("load1 lut_i01", 64'(lut_out(init_a, 5'h01)), 64'(0));
        run_a("load2", 1'b0, 32'h8000_0001, 32'hCAFE_F00D);
        run_a("restore", 1'b1, 32'h1234_5678, 32'h8000_0001);

        // Two-LUT chain: LUT 0 is the low word.
        bce = 0; bfirst = 0; brb_n = 0; brb_cyc = 0; brdy = 0; bbusy_bad = 0; brb = '0;
        ld_data_b  = {32'h1234_5678, 32'h9ABC_DEF0};
        ld_valid_b = 1'b1;
        tick;
        ld_valid_b = 1'b0;
        ld_data_b  = '1;
        for (int c = 1; c <= int'(WB) + 4; c++) begin
            if (ce_b) begin
                bce++;
                if (bfirst == 0) bfirst = c;
            end
            if (busy_b !== ce_b) bbusy_bad++;
            if (rb_valid_b) begin
                brb_n++;
                brb_cyc = c;
                brb     = rb_data_b;
            end
            if (ld_ready_b && brdy == 0) brdy = c;
            tick;
        end
        chk("lut2 ce_cycles", 64'(bce), 64'(64));
        chk("lut2 ce_first", 64'(bfirst), 64'(1));
        chk("lut2 busy", 64'(bbusy_bad), 64'(0));
        chk("lut2 rb_pulses", 64'(brb_n), 64'(1));
        chk("lut2 rb_cycle", 64'(brb_cyc), 64'(65));
        chk("lut2 ready_cycle", 64'(brdy), 64'(66));
        chk("lut2 rb_data", brb, 64'(0));
        chk("lut2 lut0", 64'(init_b0), 64'(32'h9ABC_DEF0));
        chk("lut2 lut1", 64'(init_b1), 64'(32'h1234_5678));
        chk("lut2 lut1_i00", 64'(lut_out(init_b1, 5'h00)), 64'(0));
        chk("lut2 lut0_i1f", 64'(lut_out(init_b0, 5'h1F)), 64'(1));

        // LD_VALID held with data changing every cycle: one accept per 34 cycles.
        acc_n = 0; rb_n2 = 0; last_acc = -1; gap_bad = 0;
        ld_valid_a   = 1'b1;
        ld_restore_a = 1'b0;
        for (int c = 0; c < 110; c++) begin
            ld_data_a = $urandom;
            if (rb_valid_a) begin
                if (rb_n2 < 4) rb_log[rb_n2] = rb_data_a;
                rb_n2++;
            end
            if (ld_ready_a) begin
                if (acc_n < 4) acc_data[acc_n] = ld_data_a;
                if (last_acc >= 0 && c - last_acc != 34) gap_bad++;
                last_acc = c;
                acc_n++;
            end
            if (ld_ready_a && ce_a) gap_bad++;
            tick;
        end
        ld_valid_a = 1'b0;
        for (int c = 0; c < 60 && !ld_ready_a; c++) begin
            if (rb_valid_a) begin
                if (rb_n2 < 4) rb_log[rb_n2] = rb_data_a;
                rb_n2++;
            end
            tick;
        end
        chk("hold drained", 64'(ld_ready_a), 64'(1));
        chk("hold accepts", 64'(acc_n), 64'(4));
        chk("hold spacing", 64'(gap_bad), 64'(0));
        chk("hold rb_pulses", 64'(rb_n2), 64'(4));
        chk("hold rb0", 64'(rb_log[0]), 64'(32'h8000_0001));
        chk("hold rb1", 64'(rb_log[1]), 64'(acc_data[0]));
        chk("hold rb2", 64'(rb_log[2]), 64'(acc_data[1]));
        chk("hold rb3", 64'(rb_log[3]), 64'(acc_data[2]));
        chk("hold lut_init", 64'(init_a), 64'(acc_data[3]));

        // Abort a transfer with reset in SHIFT cycle 10 (nine shifts done).
        tick;
        x_prev     = init_a;
        d_abort    = 32'hDEAD_BEEF;
        partial    = {x_prev[22:0], d_abort[31:23]};
        ld_data_a  = d_abort;
        ld_valid_a = 1'b1;
        tick;
        ld_valid_a = 1'b0;
        repeat (9) tick;
        chk("abort ce_before", 64'(ce_a), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("abort ce_async", 64'(ce_a), 64'(0));
        chk("abort ready_in_rst", 64'(ld_ready_a), 64'(1));
        rb_seen = 0;
        repeat (2) begin
            tick;
            if (rb_valid_a) rb_seen++;
        end
        rst_n = 1'b1;
        tick;
        chk("abort ready_after", 64'(ld_ready_a), 64'(1));
        chk("abort rb_data_rst", 64'(rb_data_a), 64'(0));
        repeat (3) begin
            if (rb_valid_a) rb_seen++;
            tick;
        end
        chk("abort no_rb_valid", 64'(rb_seen), 64'(0));
        chk("abort partial_image", 64'(init_a), 64'(partial));
        run_a("fresh", 1'b0, 32'h0F0F_1234, partial);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
